matmul_lanes: RTL and testbench

//  Multi-lane successor to the single-MAC matmul engine. Computes M3[A x C] = M1[A x B] * M2^T.
//  M1 and M2 are read one row/column per word from external RAMs. LANES products are summed per cycle.

---
 rtl/matmul_lanes.sv | 187 ++++++++++++++++++
 tb/tb_matmul_lanes.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_lanes.sv
// Multi-lane matrix-multiply engine computing M3 = M1 * M2^T, summing LANES products per cycle.
// Operands come from external RAMs with RD_LAT read latency; results go to a flat result RAM.
module matmul_lanes #(
  parameter int A        = 16,
  parameter int B        = 32,
  parameter int C        = 24,
  parameter int BITS     = 8,
  parameter int LANES    = 4,
  parameter int OUT_BITS = BITS * 4,
  parameter int RD_LAT   = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   signed_mode,
  output logic                   busy,
  output logic                   done,
  output logic [$clog2(A)-1:0]   m1_addr,
  input  logic [B*BITS-1:0]      m1_data,
  output logic [$clog2(C)-1:0]   m2_addr,
  input  logic [B*BITS-1:0]      m2_data,
  output logic [$clog2(A*C)-1:0] m3_wr_addr,
  output logic [OUT_BITS-1:0]    m3_wr_data,
  output logic                   m3_wr_ena
);

  localparam int K  = B / LANES;
  localparam int KW = (K > 1) ? $clog2(K) : 1;
  localparam int LW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam int RW = $clog2(A);
  localparam int CW = $clog2(C);
  localparam int FW = $clog2(A * C);

  generate
    if ((B % LANES) != 0) begin : g_lanesCheck
      $error("matmul_lanes: LANES must divide B");
    end
    if (RD_LAT < 1 || RD_LAT > 3) begin : g_latCheck
      $error("matmul_lanes: RD_LAT must be 1..3");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ACCUM,
    S_WRITE,
    S_FIN
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [1:0]          r_rstSync;
  logic                w_rstN;
  logic                r_signed;
  logic                r_busy;
  logic                r_done;
  logic [RW-1:0]       r_row;
  logic [CW-1:0]       r_col;
  logic [KW-1:0]       r_chunk;
  logic [LW-1:0]       r_latCnt;
  logic [OUT_BITS-1:0] r_acc;
  logic [OUT_BITS-1:0] r_wrData;
  logic [FW-1:0]       r_wrAddr;
  logic                r_wrEna;
  logic [OUT_BITS-1:0] w_chunkSum;
  logic [OUT_BITS-1:0] w_accNext;
  logic [FW-1:0]       w_flatAddr;
  logic                w_lastChunk;
  logic                w_latDone;
  logic                w_lastElem;

  function automatic logic [OUT_BITS-1:0] extend(input logic [BITS-1:0] v, input logic sgn);
    return sgn ? {{(OUT_BITS-BITS){v[BITS-1]}}, v} : {{(OUT_BITS-BITS){1'b0}}, v};
  endfunction

  // Reset asserts asynchronously but releases only after two clean clock edges
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rstSync <= '0;
    else        r_rstSync <= {r_rstSync[0], 1'b1};
  end
  assign w_rstN = r_rstSync[1];

  assign w_lastChunk = (r_chunk == KW'(K - 1));
  assign w_latDone   = (r_latCnt == LW'(RD_LAT - 1));
  assign w_lastElem  = (r_row == RW'(A - 1)) && (r_col == CW'(C - 1));
  assign w_flatAddr  = FW'(r_row) * FW'(C) + FW'(r_col);
  assign w_accNext   = r_acc + w_chunkSum;

  always_comb begin
    w_chunkSum = '0;
    for (int l = 0; l < LANES; l++) begin
      w_chunkSum = w_chunkSum
                 + extend(m1_data[(int'(r_chunk) * LANES + l) * BITS +: BITS], r_signed)
                 * extend(m2_data[(int'(r_chunk) * LANES + l) * BITS +: BITS], r_signed);
    end
  end

  always_ff @(posedge clk or negedge w_rstN) begin
    if (!w_rstN) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_FETCH;
      S_FETCH: if (w_latDone) w_next = S_ACCUM;
      S_ACCUM: if (w_lastChunk) w_next = S_WRITE;
      S_WRITE: w_next = w_lastElem ? S_FIN : S_FETCH;
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // The result strobe is raised on the last accumulate so it is valid during WRITE
  always_ff @(posedge clk or negedge w_rstN) begin
    if (!w_rstN) begin
      r_signed <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_row    <= '0;
      r_col    <= '0;
      r_chunk  <= '0;
      r_latCnt <= '0;
      r_acc    <= '0;
      r_wrData <= '0;
      r_wrAddr <= '0;
      r_wrEna  <= 1'b0;
    end else begin
      r_done  <= 1'b0;
      r_wrEna <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_signed <= signed_mode;
            r_row    <= '0;
            r_col    <= '0;
            r_latCnt <= '0;
            r_busy   <= 1'b1;
          end
        end
        S_FETCH: begin
          r_acc    <= '0;
          r_chunk  <= '0;
          r_latCnt <= w_latDone ? '0 : r_latCnt + LW'(1);
        end
        S_ACCUM: begin
          r_acc <= w_accNext;
          if (w_lastChunk) begin
            r_chunk  <= '0;
            r_wrEna  <= 1'b1;
            r_wrData <= w_accNext;
            r_wrAddr <= w_flatAddr;
          end else begin
            r_chunk <= r_chunk + KW'(1);
          end
        end
        S_WRITE: begin
          r_latCnt <= '0;
          if (!w_lastElem) begin
            if (r_col == CW'(C - 1)) begin
              r_col <= '0;
              r_row <= r_row + RW'(1);
            end else begin
              r_col <= r_col + CW'(1);
            end
          end
        end
        S_FIN: begin
          r_done <= 1'b1;
          r_busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign m1_addr    = r_row;
  assign m2_addr    = r_col;
  assign m3_wr_addr = r_wrAddr;
  assign m3_wr_data = r_wrData;
  assign m3_wr_ena  = r_wrEna;

endmodule

// File: tb/tb_matmul_lanes.sv
// Self-checking bench: two matmul_lanes instances (different LANES/RD_LAT/OUT_BITS) share
// operand memories and are checked every cycle against a timing-and-arithmetic model.
module tb_matmul_lanes;

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic signed_mode;
  logic [7:0] m1Mem [2][4];
  logic [7:0] m2Mem [2][4];
  int nCompared = 0;
  int nMismatched = 0;

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference value of one result element from the current memories, wrapped to ob bits
  function automatic longint elemVal(input int r, input int c, input bit sgn, input int ob);
    longint s = 0;
    for (int j = 0; j < 4; j++) begin
      int a = sgn ? int'($signed(m1Mem[r][j])) : int'(m1Mem[r][j]);
      int b = sgn ? int'($signed(m2Mem[c][j])) : int'(m2Mem[c][j]);
      s += longint'(a * b);
    end
    return s & ((64'sd1 <<< ob) - 1);
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int LN  = (g == 0) ? 2 : 4;
    localparam int RL  = (g == 0) ? 1 : 3;
    localparam int OB  = (g == 0) ? 16 : 32;
    localparam int KK  = 4 / LN;
    localparam int PER = RL + KK + 1;
    localparam int NN  = 4;

    logic          busy, done, ena;
    logic [0:0]    m1a, m2a;
    logic [1:0]    wra;
    logic [OB-1:0] wrd;
    logic [31:0]   m1d, m2d;
    logic [0:0]    m1P [RL];
    logic [0:0]    m2P [RL];
    bit            running = 1'b0;
    bit            expBusy = 1'b0;
    bit            expDone = 1'b0;
    bit            expEna = 1'b0;
    int            tick = 0;
    int            expAddr = 0;
    int            expElem = 0;
    int            wrCount = 0;
    longint        expData = 0;
    longint        res [NN];

    matmul_lanes #(.A(2), .B(4), .C(2), .BITS(8), .LANES(LN), .OUT_BITS(OB), .RD_LAT(RL)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(signed_mode),
      .busy(busy), .done(done),
      .m1_addr(m1a), .m1_data(m1d), .m2_addr(m2a), .m2_data(m2d),
      .m3_wr_addr(wra), .m3_wr_data(wrd), .m3_wr_ena(ena)
    );

    // Operand RAMs with RL cycles of read latency
    always @(posedge clk) begin
      m1P[0] <= m1a;
      m2P[0] <= m2a;
      for (int i = 1; i < RL; i++) begin
        m1P[i] <= m1P[i-1];
        m2P[i] <= m2P[i-1];
      end
    end

    always_comb begin
      m1d = '0;
      m2d = '0;
      for (int j = 0; j < 4; j++) begin
        m1d[j*8 +: 8] = m1Mem[m1P[RL-1]][j];
        m2d[j*8 +: 8] = m2Mem[m2P[RL-1]][j];
      end
    end

    // Model: element k writes at tick RL+KK+k*PER after the accepting edge, done at NN*PER+1
    always @(posedge clk or negedge rst_n) begin : mdl
      int t;
      int k;
      if (!rst_n) begin
        running <= 1'b0;
        expBusy <= 1'b0;
        expDone <= 1'b0;
        expEna  <= 1'b0;
        expAddr <= 0;
        expData <= 0;
        expElem <= 0;
        tick    <= 0;
      end else begin
        expDone <= 1'b0;
        expEna  <= 1'b0;
        if (!running) begin
          if (start) begin
            running <= 1'b1;
            tick    <= 0;
            expBusy <= 1'b1;
            expElem <= 0;
            for (int e = 0; e < NN; e++) res[e] <= elemVal(e / 2, e % 2, signed_mode, OB);
          end
        end else begin
          t = tick + 1;
          tick <= t;
          if (t == NN * PER + 1) begin
            running <= 1'b0;
            expBusy <= 1'b0;
            expDone <= 1'b1;
          end else begin
            if (t % PER == 0 && t / PER < NN) expElem <= t / PER;
            if (t >= RL + KK && (t - RL - KK) % PER == 0 && (t - RL - KK) / PER < NN) begin
              k = (t - RL - KK) / PER;
              expEna  <= 1'b1;
              expAddr <= k;
              expData <= res[k];
            end
          end
        end
      end
    end

    always @(negedge clk) begin
      checkOutput($sformatf("busy[%0d]", g), 64'(busy), 64'(expBusy));
      checkOutput($sformatf("done[%0d]", g), 64'(done), 64'(expDone));
      checkOutput($sformatf("wrEna[%0d]", g), 64'(ena), 64'(expEna));
      checkOutput($sformatf("wrData[%0d]", g), 64'(wrd), 64'(expData));
      checkOutput($sformatf("m1Addr[%0d]", g), 64'(m1a), 64'(expElem / 2));
      checkOutput($sformatf("m2Addr[%0d]", g), 64'(m2a), 64'(expElem % 2));
      if (expEna) checkOutput($sformatf("wrAddr[%0d]", g), 64'(wra), 64'(expAddr));
      if (ena) wrCount <= wrCount + 1;
    end
  end

  task automatic waitIdle();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!g_dut[0].running && !g_dut[1].running) return;
    end
    nCompared++;
    nMismatched++;
    $display("[TB] FAIL waitIdle: got timeout expected idle within 300 cycles");
  endtask

  // Starts a product; optionally disturbs it with a start pulse and mode flip mid-run
  task automatic applyStimulus(input bit sgn, input int disturbAt);
    int c0 = g_dut[0].wrCount;
    int c1 = g_dut[1].wrCount;
    @(negedge clk);
    start = 1'b1;
    signed_mode = sgn;
    @(negedge clk);
    start = 1'b0;
    if (disturbAt > 0) begin
      repeat (disturbAt) @(negedge clk);
      start = 1'b1;
      signed_mode = ~sgn;
      @(negedge clk);
      start = 1'b0;
    end
    waitIdle();
    @(negedge clk);
    checkOutput("wrCount0", 64'(g_dut[0].wrCount - c0), 64'd4);
    checkOutput("wrCount1", 64'(g_dut[1].wrCount - c1), 64'd4);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    signed_mode = 1'b0;
    for (int r = 0; r < 2; r++)
      for (int j = 0; j < 4; j++) begin
        m1Mem[r][j] = 8'd0;
        m2Mem[r][j] = 8'd0;
      end
    repeat (3) @(negedge clk);
    checkOutput("rstBusy0", 64'(g_dut[0].busy), 64'd0);
    checkOutput("rstEna1", 64'(g_dut[1].ena), 64'd0);
    checkOutput("rstData0", 64'(g_dut[0].wrd), 64'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Basic unsigned product
    m1Mem[0] = '{8'd1, 8'd2, 8'd3, 8'd4};
    m1Mem[1] = '{8'd5, 8'd6, 8'd7, 8'd8};
    m2Mem[0] = '{8'd1, 8'd1, 8'd1, 8'd1};
    m2Mem[1] = '{8'd0, 8'd1, 8'd0, 8'd1};
    checkOutput("model_t1_0", 64'(elemVal(0, 0, 1'b0, 16)), 64'd10);
    checkOutput("model_t1_1", 64'(elemVal(0, 1, 1'b0, 16)), 64'd6);
    checkOutput("model_t1_2", 64'(elemVal(1, 0, 1'b0, 16)), 64'd26);
    checkOutput("model_t1_3", 64'(elemVal(1, 1, 1'b0, 16)), 64'd14);
    applyStimulus(1'b0, 0);
    checkOutput("t1_last0", 64'(g_dut[0].wrd), 64'd14);

    // Signed versus unsigned interpretation of the same bits
    m1Mem[0][0] = 8'hFF;
    checkOutput("model_t2_s0", 64'(elemVal(0, 0, 1'b1, 16)), 64'd8);
    checkOutput("model_t2_s1", 64'(elemVal(0, 1, 1'b1, 16)), 64'd6);
    checkOutput("model_t2_u0", 64'(elemVal(0, 0, 1'b0, 16)), 64'd264);
    applyStimulus(1'b1, 0);
    applyStimulus(1'b0, 0);

    // Accumulator wrap with all-ones operands
    for (int r = 0; r < 2; r++)
      for (int j = 0; j < 4; j++) begin
        m1Mem[r][j] = 8'hFF;
        m2Mem[r][j] = 8'hFF;
      end
    checkOutput("model_t3_16", 64'(elemVal(1, 1, 1'b0, 16)), 64'd63492);
    applyStimulus(1'b0, 0);
    checkOutput("t3_last0", 64'(g_dut[0].wrd), 64'd63492);
    checkOutput("t3_last1", 64'(g_dut[1].wrd), 64'd260100);
    applyStimulus(1'b1, 0);
    checkOutput("t3_signedLast0", 64'(g_dut[0].wrd), 64'd4);

    // Identity operands
    m1Mem[0] = '{8'd1, 8'd0, 8'd0, 8'd0};
    m1Mem[1] = '{8'd0, 8'd1, 8'd0, 8'd0};
    m2Mem[0] = '{8'd1, 8'd0, 8'd0, 8'd0};
    m2Mem[1] = '{8'd0, 8'd1, 8'd0, 8'd0};
    checkOutput("model_t4_01", 64'(elemVal(0, 1, 1'b0, 32)), 64'd0);
    checkOutput("model_t4_11", 64'(elemVal(1, 1, 1'b0, 32)), 64'd1);
    applyStimulus(1'b0, 0);

    // Randomized operands, some runs disturbed by a mid-run start and mode flip
    for (int n = 0; n < 8; n++) begin
      for (int r = 0; r < 2; r++)
        for (int j = 0; j < 4; j++) begin
          m1Mem[r][j] = 8'($urandom_range(0, 255));
          m2Mem[r][j] = (n % 3 == 0) ? 8'h80 : 8'($urandom_range(0, 255));
        end
      applyStimulus(1'($urandom_range(0, 1)), (n % 2 == 1) ? int'($urandom_range(2, 12)) : 0);
    end

    // Restart in the cycle right after done of the faster instance
    @(negedge clk);
    start = 1'b1;
    signed_mode = 1'b1;
    @(negedge clk);
    start = 1'b0;
    begin : waitDone
      bit seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
        @(negedge clk);
        if (g_dut[0].done) seen = 1'b1;
      end
      checkOutput("doneSeen", 64'(seen), 64'd1);
    end
    start = 1'b1;
    signed_mode = 1'b0;
    @(negedge clk);
    start = 1'b0;
    waitIdle();

    // Reset dropped in the middle of an accumulate
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midRstBusy0", 64'(g_dut[0].busy), 64'd0);
    checkOutput("midRstEna0", 64'(g_dut[0].ena), 64'd0);
    checkOutput("midRstDone0", 64'(g_dut[0].done), 64'd0);
    checkOutput("midRstBusy1", 64'(g_dut[1].busy), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    for (int r = 0; r < 2; r++)
      for (int j = 0; j < 4; j++) begin
        m1Mem[r][j] = 8'($urandom_range(0, 255));
        m2Mem[r][j] = 8'($urandom_range(0, 255));
      end
    applyStimulus(1'b1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
